bt_move_ctrl: RTL and testbench

BT_MOVE_CTRL -- requirements
Module: bt_move_ctrl

---
 rtl/gobang_pkg.sv | 18 +
 rtl/bt_cursor_step.sv | 23 ++
 rtl/bt_move_ctrl.sv | 132 +++++++++++++
 tb/tb_bt_move_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// rtl/gobang_pkg.sv - shared board size and Bluetooth command codes
package gobang_pkg;

    localparam int BOARD_N_DEF = 15;

    localparam logic [7:0] BTN_NOP   = 8'h00;
    localparam logic [7:0] BTN_UP    = 8'h01;
    localparam logic [7:0] BTN_DOWN  = 8'h02;
    localparam logic [7:0] BTN_LEFT  = 8'h03;
    localparam logic [7:0] BTN_RIGHT = 8'h04;
    localparam logic [7:0] BTN_PLACE = 8'h05;
    localparam logic [7:0] BTN_JUMP  = 8'h06;

    function automatic logic on_board(input logic [7:0] v, input logic [7:0] n);
        return v < n;
    endfunction

endpackage

// File: rtl/bt_cursor_step.sv
// rtl/bt_cursor_step.sv - one-axis cursor step with wrap at both board edges
module bt_cursor_step #(
    parameter int BOARD_N = gobang_pkg::BOARD_N_DEF
) (
    input  logic [3:0] cur,
    input  logic       dir_inc,
    input  logic       dir_dec,
    output logic [3:0] next
);

    localparam logic [3:0] LAST = 4'(BOARD_N - 1);

    // Decrement wraps 0 -> LAST, increment wraps LAST -> 0, otherwise hold.
    always_comb begin
        next = cur;
        if (dir_dec) begin
            next = (cur == 4'd0) ? LAST : cur - 4'd1;
        end else if (dir_inc) begin
            next = (cur == LAST) ? 4'd0 : cur + 4'd1;
        end
    end

endmodule

// File: rtl/bt_move_ctrl.sv
// rtl/bt_move_ctrl.sv - Bluetooth cursor/placement controller (optional BT_MOVE_TIMEOUT_EN)
module bt_move_ctrl #(
    parameter int BOARD_N     = gobang_pkg::BOARD_N_DEF,
    parameter int CENTER      = 7,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] btn,
    input  logic       valid,
    input  logic       place_ack,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       place_req,
    output logic       busy,
    output logic       err,
    output logic       drop
);
    import gobang_pkg::*;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    localparam logic [7:0] N8  = 8'(BOARD_N);
    localparam logic [3:0] C4  = 4'(CENTER);

    logic [0:0] state;
    logic       cmd;
    logic       x_inc, x_dec, y_inc, y_dec;
    logic [3:0] x_step, y_step;
    logic       jump_ok;
    logic       to_hit;

    assign cmd     = valid && (state == ST_IDLE);
    assign x_inc   = cmd && (btn == BTN_RIGHT);
    assign x_dec   = cmd && (btn == BTN_LEFT);
    assign y_inc   = cmd && (btn == BTN_DOWN);
    assign y_dec   = cmd && (btn == BTN_UP);
    assign jump_ok = on_board(x, N8) && on_board(y, N8);

    bt_cursor_step #(.BOARD_N(BOARD_N)) u_step_x (
        .cur     (cursor_x),
        .dir_inc (x_inc),
        .dir_dec (x_dec),
        .next    (x_step)
    );

    bt_cursor_step #(.BOARD_N(BOARD_N)) u_step_y (
        .cur     (cursor_y),
        .dir_inc (y_inc),
        .dir_dec (y_dec),
        .next    (y_step)
    );

`ifdef BT_MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Wait-cycle counter: held at zero in IDLE so it starts clean on every WAIT_ACK entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign to_hit         = 1'b0;
`endif

    // Command decode, cursor update and placement handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cursor_x  <= C4;
            cursor_y  <= C4;
            place_req <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            err  <= 1'b0;
            drop <= 1'b0;
            if (state == ST_IDLE) begin
                if (valid) begin
                    case (btn)
                        BTN_NOP: ;
                        BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT: begin
                            cursor_x <= x_step;
                            cursor_y <= y_step;
                        end
                        BTN_PLACE: begin
                            place_req <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_WAIT_ACK;
                        end
                        BTN_JUMP: begin
                            if (jump_ok) begin
                                cursor_x <= x[3:0];
                                cursor_y <= y[3:0];
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        default: err <= 1'b1;
                    endcase
                end
            end else begin
                drop <= valid;
                if (place_ack) begin
                    place_req <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end else if (to_hit) begin
                    place_req <= 1'b0;
                    busy      <= 1'b0;
                    err       <= 1'b1;
                    state     <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bt_move_ctrl.sv
// tb/tb_bt_move_ctrl.sv - scoreboard bench for bt_move_ctrl against a behavioural model
module tb_bt_move_ctrl;

    localparam int N  = 15;
    localparam int CT = 7;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] x = 8'd0;
    logic [7:0] y = 8'd0;
    logic [7:0] btn = 8'd0;
    logic       valid = 1'b0;
    logic       place_ack = 1'b0;
    logic [3:0] cursor_x, cursor_y;
    logic       place_req, busy, err, drop;

    bt_move_ctrl #(.BOARD_N(N), .CENTER(CT), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .btn       (btn),
        .valid     (valid),
        .place_ack (place_ack),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .place_req (place_req),
        .busy      (busy),
        .err       (err),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int cx;
        int cy;
        bit bz;
        bit er;
        bit dr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int m_x = CT;
    int m_y = CT;
    bit m_busy = 0;
    int m_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_entry due=%0d now=%0d", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (cursor_x !== 4'(mon_e.cx) || cursor_y !== 4'(mon_e.cy) ||
                place_req !== mon_e.bz || busy !== mon_e.bz ||
                err !== mon_e.er || drop !== mon_e.dr) begin
                errors++;
                $display("FAIL outputs cyc=%0d got x=%0d y=%0d req=%0b busy=%0b err=%0b drop=%0b exp x=%0d y=%0d req=%0b busy=%0b err=%0b drop=%0b",
                         cyc, cursor_x, cursor_y, place_req, busy, err, drop,
                         mon_e.cx, mon_e.cy, mon_e.bz, mon_e.bz, mon_e.er, mon_e.dr);
            end
        end
    end

    task automatic step(input bit v, input int ix, input int iy, input int ib, input bit a);
        exp_t e;
        bit   e_err;
        bit   e_drop;
        @(negedge clk);
        #2;
        valid     = v;
        x         = 8'(ix);
        y         = 8'(iy);
        btn       = 8'(ib);
        place_ack = a;
        e_err  = 0;
        e_drop = 0;
        if (m_busy) begin
            if (v) e_drop = 1;
            if (a) begin
                m_busy = 0;
            end else begin
`ifdef BT_MOVE_TIMEOUT_EN
                m_wait++;
                if (m_wait == TO) begin
                    m_busy = 0;
                    e_err  = 1;
                end
`endif
            end
        end else if (v) begin
            case (ib)
                0: ;
                1: m_y = (m_y + N - 1) % N;
                2: m_y = (m_y + 1) % N;
                3: m_x = (m_x + N - 1) % N;
                4: m_x = (m_x + 1) % N;
                5: begin m_busy = 1; m_wait = 0; end
                6: begin
                    if (ix < N && iy < N) begin
                        m_x = ix;
                        m_y = iy;
                    end else begin
                        e_err = 1;
                    end
                end
                default: e_err = 1;
            endcase
        end
        e = '{cyc + 1, m_x, m_y, m_busy, e_err, e_drop};
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b1;
        valid     = 1'b0;
        place_ack = 1'b0;
        #1;
        m_x    = CT;
        m_y    = CT;
        m_busy = 0;
        m_wait = 0;
        checks++;
        if (cursor_x !== 4'(CT) || cursor_y !== 4'(CT) || place_req !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got x=%0d y=%0d req=%0b busy=%0b err=%0b drop=%0b exp x=%0d y=%0d all flags 0",
                     cursor_x, cursor_y, place_req, busy, err, drop, CT, CT);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int r;
        do_reset();

        step(1, 0, 0, 3, 0);
        step(1, 0, 0, 6, 0);
        step(1, 0, 0, 1, 0);
        step(1, 14, 3, 6, 0);
        step(1, 0, 0, 4, 0);
        step(1, 3, 12, 6, 0);
        step(1, 15, 2, 6, 0);
        step(1, 3, 16, 6, 0);

        step(1, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 2, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        step(1, 0, 0, 8'h5A, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0);
        step(1, 0, 0, 4, 1);
        step(1, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);

`ifdef BT_MOVE_TIMEOUT_EN
        step(1, 0, 0, 5, 0);
        repeat (10) step(0, 0, 0, 0, 0);
`endif

        repeat (1500) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                if (r == 7) r = $urandom_range(7, 255);
                else if (r > 7) r = 0;
                step($urandom_range(0, 1) == 1, $urandom_range(0, 17), $urandom_range(0, 17),
                     r, $urandom_range(0, 6) == 0);
            end
        end

        step(0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
